// File: rtl/ad8251_autorange.sv
// Two-channel auto gain-ranging controller for AD8251 PGAs: one ranging FSM per
// channel picks a gain code (0..3 = x1..x8) that keeps the window peak in band.
module ad8251_autorange_ch #(
  parameter int                   ADC_WIDTH     = 16,
  parameter logic [15:0]          WINDOW        = 16'd1000,
  parameter logic [ADC_WIDTH-2:0] HI_THRESH     = 24576,
  parameter logic [ADC_WIDTH-2:0] LO_THRESH     = 6144,
  parameter logic [15:0]          SETTLE_CYCLES = 16'd400
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [ADC_WIDTH-1:0] adc_in,
  input  logic                 adc_valid_in,
  input  logic                 auto_in,
  input  logic [1:0]           manual_gain_in,
  output logic [1:0]           gain_out,
  output logic                 settling_out,
  output logic                 overrange_out
);
  localparam int MW = ADC_WIDTH - 1;
  localparam logic [MW-1:0] MAG_MAX  = '1;
  localparam logic [15:0]   WIN_LAST = WINDOW - 16'd1;

  typedef enum logic [1:0] {S_MANUAL, S_SETTLE, S_MEASURE} state_t;

  state_t         state;
  logic [15:0]    settle_cnt;
  logic [15:0]    samp_cnt;
  logic [MW-1:0]  peak;
  logic [ADC_WIDTH-1:0] neg;
  logic [MW-1:0]  mag;
  logic [MW-1:0]  pk_new;
  logic           clip;
  logic           win_end;

  // Saturating |x|: the most negative code folds onto the positive full scale.
  assign neg = ~adc_in + {{MW{1'b0}}, 1'b1};
  always_comb begin
    mag = adc_in[MW-1:0];
    if (adc_in[ADC_WIDTH-1])
      mag = (adc_in == {1'b1, {MW{1'b0}}}) ? MAG_MAX : neg[MW-1:0];
  end

  assign pk_new       = (mag > peak) ? mag : peak;
  assign clip         = (mag == MAG_MAX);
  assign win_end      = (samp_cnt == WIN_LAST);
  assign settling_out = (state == S_SETTLE);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= S_MANUAL;
      gain_out      <= 2'd0;
      overrange_out <= 1'b0;
      settle_cnt    <= 16'd0;
      samp_cnt      <= 16'd0;
      peak          <= '0;
    end else begin
      overrange_out <= 1'b0;
      if (!auto_in) begin
        state    <= S_MANUAL;
        gain_out <= manual_gain_in;
      end else begin
        unique case (state)
          S_MANUAL: begin
            state      <= S_SETTLE;
            settle_cnt <= SETTLE_CYCLES;
          end
          // <= 1 so a zero settle time still leaves after one cycle
          S_SETTLE: begin
            if (settle_cnt <= 16'd1) begin
              state    <= S_MEASURE;
              peak     <= '0;
              samp_cnt <= 16'd0;
            end else begin
              settle_cnt <= settle_cnt - 16'd1;
            end
          end
          S_MEASURE: begin
            if (adc_valid_in) begin
              if (clip && gain_out != 2'd0) begin
                gain_out   <= gain_out - 2'd1;
                state      <= S_SETTLE;
                settle_cnt <= SETTLE_CYCLES;
              end else begin
                overrange_out <= clip;
                if (win_end) begin
                  peak     <= '0;
                  samp_cnt <= 16'd0;
                  if (pk_new >= HI_THRESH && gain_out != 2'd0) begin
                    gain_out   <= gain_out - 2'd1;
                    state      <= S_SETTLE;
                    settle_cnt <= SETTLE_CYCLES;
                  end else if (pk_new < LO_THRESH && gain_out != 2'd3) begin
                    gain_out   <= gain_out + 2'd1;
                    state      <= S_SETTLE;
                    settle_cnt <= SETTLE_CYCLES;
                  end
                end else begin
                  peak     <= pk_new;
                  samp_cnt <= samp_cnt + 16'd1;
                end
              end
            end
          end
          default: state <= S_MANUAL;
        endcase
      end
    end
  end
endmodule

module ad8251_autorange #(
  parameter int                   ADC_WIDTH     = 16,
  parameter logic [15:0]          WINDOW        = 16'd1000,
  parameter logic [ADC_WIDTH-2:0] HI_THRESH     = 24576,
  parameter logic [ADC_WIDTH-2:0] LO_THRESH     = 6144,
  parameter logic [15:0]          SETTLE_CYCLES = 16'd400
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [ADC_WIDTH-1:0] adc0_in,
  input  logic [ADC_WIDTH-1:0] adc1_in,
  input  logic                 adc_valid_in,
  input  logic                 auto0_in,
  input  logic                 auto1_in,
  input  logic [1:0]           manual_gain0_in,
  input  logic [1:0]           manual_gain1_in,
  output logic [1:0]           gain0_out,
  output logic [1:0]           gain1_out,
  output logic [1:0]           settling_out,
  output logic [1:0]           overrange_out
);
  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0][ADC_WIDTH-1:0] adc;
  logic [NUM_CH-1:0][1:0]           man_gain;
  logic [NUM_CH-1:0][1:0]           gain;
  logic [NUM_CH-1:0]                auto_en;

  assign adc      = {adc1_in, adc0_in};
  assign man_gain = {manual_gain1_in, manual_gain0_in};
  assign auto_en  = {auto1_in, auto0_in};
  assign gain0_out = gain[0];
  assign gain1_out = gain[1];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ad8251_autorange_ch #(
      .ADC_WIDTH(ADC_WIDTH), .WINDOW(WINDOW), .HI_THRESH(HI_THRESH),
      .LO_THRESH(LO_THRESH), .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_ch (
      .clk_in        (clk_in),
      .rst_n_in      (rst_n_in),
      .adc_in        (adc[i]),
      .adc_valid_in  (adc_valid_in),
      .auto_in       (auto_en[i]),
      .manual_gain_in(man_gain[i]),
      .gain_out      (gain[i]),
      .settling_out  (settling_out[i]),
      .overrange_out (overrange_out[i])
    );
  end
endmodule

// File: tb/tb_ad8251_autorange.sv
// Directed bench for ad8251_autorange: stimulus queues expected output snapshots,
// a negedge monitor pops and compares them on the cycle they are due.
module tb_ad8251_autorange;
  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [15:0] adc0_in, adc1_in;
  logic        adc_valid_in;
  logic        auto0_in, auto1_in;
  logic [1:0]  manual_gain0_in, manual_gain1_in;
  logic [1:0]  gain0_out, gain1_out, settling_out, overrange_out;

  ad8251_autorange #(.ADC_WIDTH(16), .WINDOW(16'd4), .HI_THRESH(15'd24576),
                     .LO_THRESH(15'd6144), .SETTLE_CYCLES(16'd10)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .adc0_in(adc0_in), .adc1_in(adc1_in),
    .adc_valid_in(adc_valid_in), .auto0_in(auto0_in), .auto1_in(auto1_in),
    .manual_gain0_in(manual_gain0_in), .manual_gain1_in(manual_gain1_in),
    .gain0_out(gain0_out), .gain1_out(gain1_out),
    .settling_out(settling_out), .overrange_out(overrange_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          cyc;
    string       name;
    logic [1:0]  g0, g1, s, o;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [1:0] eg0, eg1, es, eo;

  always @(posedge clk_in) cyc <= cyc + 1;

  // monitor
  always @(negedge clk_in) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      n_tests++;
      if (e.cyc != cyc || gain0_out !== e.g0 || gain1_out !== e.g1 ||
          settling_out !== e.s || overrange_out !== e.o) begin
        n_fail++;
        $display("FAIL %s @cyc %0d (due %0d): got g0=%0d g1=%0d set=%b ovr=%b, expected g0=%0d g1=%0d set=%b ovr=%b",
                 e.name, cyc, e.cyc, gain0_out, gain1_out, settling_out, overrange_out,
                 e.g0, e.g1, e.s, e.o);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string nm);
    exp_t e;
    e.cyc = cyc; e.name = nm;
    e.g0 = eg0; e.g1 = eg1; e.s = es; e.o = eo;
    sbq.push_back(e);
  endtask

  task automatic strobe(input int a0, input int a1);
    adc0_in = 16'(a0);
    adc1_in = 16'(a1);
    adc_valid_in = 1'b1;
    tick();
    adc_valid_in = 1'b0;
  endtask

  // Called on the edge that entered SETTLE: high 10 cycles in total, then low.
  task automatic settle_wait(input logic [1:0] m);
    repeat (9) begin tick(); chk("settle_hi"); end
    es = es & ~m;
    tick(); chk("settle_lo");
  endtask

  initial begin
    rst_n_in = 1'b0; auto0_in = 1'b0; auto1_in = 1'b0;
    manual_gain0_in = 2'd2; manual_gain1_in = 2'd1;
    adc0_in = '0; adc1_in = '0; adc_valid_in = 1'b0;
    eg0 = 0; eg1 = 0; es = 0; eo = 0;

    tick(); tick(); chk("reset");
    rst_n_in = 1'b1;
    tick(); eg0 = 2; eg1 = 1; chk("manual");

    // upward ranging; samples scale with the gain the amp is set to
    manual_gain0_in = 2'd0; tick(); eg0 = 0; chk("manual0");
    auto0_in = 1'b1; tick(); es = 2'b01; chk("settle_start");
    settle_wait(2'b01);
    strobe(3000, 0); strobe(3000, 0); strobe(3000, 0); chk("win_mid");
    strobe(3000, 0); eg0 = 1; es = 2'b01; chk("up_0_1");
    settle_wait(2'b01);
    repeat (3) strobe(6000, 0); chk("win_mid1");
    strobe(6000, 0); eg0 = 2; es = 2'b01; chk("up_1_2");
    settle_wait(2'b01);
    repeat (4) strobe(12000, 0); chk("hold_2");

    // reach gain 3, then a single large sample pulls it back
    repeat (4) strobe(1000, 0); eg0 = 3; es = 2'b01; chk("up_2_3");
    settle_wait(2'b01);
    strobe(100, 0); strobe(-25000, 0); strobe(100, 0); chk("dn_mid");
    strobe(100, 0); eg0 = 2; es = 2'b01; chk("dn_peak");
    settle_wait(2'b01);
    strobe(24576, 0); repeat (3) strobe(0, 0); eg0 = 1; es = 2'b01; chk("hi_exact");
    settle_wait(2'b01);
    strobe(6144, 0); repeat (3) strobe(0, 0); chk("lo_exact");

    // clip handling
    repeat (4) strobe(1000, 0); eg0 = 2; es = 2'b01; chk("up_1_2b");
    settle_wait(2'b01);
    strobe(100, 0); strobe(-32768, 0); eg0 = 1; es = 2'b01; chk("clip_g2");
    settle_wait(2'b01);
    strobe(32767, 0); eg0 = 0; es = 2'b01; chk("clip_g1");
    settle_wait(2'b01);
    strobe(-32768, 0); eo = 2'b01; chk("ovr_pulse");
    eo = 2'b00; tick(); chk("ovr_clear");

    // manual override during SETTLE
    auto0_in = 1'b0; manual_gain0_in = 2'd3; tick(); eg0 = 3; chk("to_manual");
    auto0_in = 1'b1; tick(); es = 2'b01; chk("resettle");
    manual_gain0_in = 2'd1;
    repeat (3) begin tick(); chk("settle_hold"); end
    auto0_in = 1'b0; tick(); eg0 = 1; es = 2'b00; chk("override");

    // channel independence
    auto0_in = 1'b1; auto1_in = 1'b1; tick(); es = 2'b11; chk("both_settle");
    settle_wait(2'b11);
    strobe(3000, 0); strobe(3000, -32768); eg1 = 0; es = 2'b10; chk("ch1_clip");
    strobe(3000, 0); strobe(3000, 0); eg0 = 2; es = 2'b11; chk("ch0_up");
    repeat (7) begin tick(); chk("dual_settle"); end
    tick(); es = 2'b01; chk("ch1_done");
    tick(); chk("ch0_still");
    tick(); es = 2'b00; chk("ch0_done");
    repeat (4) strobe(12000, 0); eg1 = 1; es = 2'b10; chk("ch1_up");
    tick(); tick(); chk("pre_rst");

    // asynchronous reset between clock edges
    @(negedge clk_in); #1;
    rst_n_in = 1'b0; #1;
    n_tests++;
    if (gain0_out !== 2'd0 || gain1_out !== 2'd0 || settling_out !== 2'b00 ||
        overrange_out !== 2'b00) begin
      n_fail++;
      $display("FAIL async_rst: got g0=%0d g1=%0d set=%b ovr=%b, expected all 0",
               gain0_out, gain1_out, settling_out, overrange_out);
    end
    eg0 = 0; eg1 = 0; es = 0; eo = 0;
    auto0_in = 1'b0; auto1_in = 1'b0;
    tick(); chk("rst_hold");
    rst_n_in = 1'b1;
    tick(); eg0 = 1; eg1 = 1; chk("post_rst");

    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk_in);
    #1;
    if (sbq.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
